// File: rtl/nor_srff_bank.sv
// -----------------------------------------------------------------------------
// nor_srff_bank
//
// A bank of CH independent, clocked set/reset latches. Each channel behaves like
// a cross-coupled NOR SR latch that is sampled on the clock. It adds:
//   - a configurable policy for set and clr arriving together,
//   - a minimum-high hold time: once q rises, a clear is deferred (pend) until
//     q has been high for MIN_HIGH cycles,
//   - registered rise/fall edge pulses,
//   - bank-wide conflict statistics (saturating counter + sticky flag).
//
// Parameters
//   CH            number of channels (1..32)
//   CONFLICT_MODE set&clr together: 0 hold, 1 set wins, 2 clr wins, 3 toggle
//   MIN_HIGH      minimum cycles q stays high before a clear may land (0..255)
//   CW            width of conflict_cnt
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst             synchronous active-high reset, overrides every other input
//   en              global update enable; 0 freezes q, pend and hold counters
//   set, clr        per-channel set / clear requests
//   clr_stat        clears conflict_cnt / conflict_sticky
//   q, qn           latch state and its complement
//   rise, fall      one-cycle pulses for 0->1 / 1->0 on the last edge
//   pend            clear accepted but waiting for the hold time to expire
//   conflict_cnt    saturating count of channel-cycles with set&clr while en=1
//   conflict_sticky set once any conflict is seen
// -----------------------------------------------------------------------------
module nor_srff_bank #(
    parameter int CH            = 8,
    parameter int CONFLICT_MODE = 0,
    parameter int MIN_HIGH      = 0,
    parameter int CW            = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [CH-1:0] set,
    input  logic [CH-1:0] clr,
    input  logic          clr_stat,
    output logic [CH-1:0] q,
    output logic [CH-1:0] qn,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic [CH-1:0] pend,
    output logic [CW-1:0] conflict_cnt,
    output logic          conflict_sticky
);

    localparam logic [7:0] HOLD_LOAD = 8'(MIN_HIGH);

    // Popcount width: enough for up to 32 channels.
    localparam int PW = 6;
    // Adder width wide enough that cnt + popcount never overflows before
    // saturation is applied, even for very narrow CW.
    localparam int SW = CW + PW;
    localparam logic [SW-1:0] CNT_MAX = {{PW{1'b0}}, {CW{1'b1}}};

    // -------------------------------------------------------------------------
    // Per-channel latch
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        logic       q_reg;
        logic       pend_reg;
        logic       rise_reg;
        logic       fall_reg;
        logic [7:0] hold_reg;

        logic       s_eff;
        logic       c_eff;
        logic       q_next;
        logic       pend_next;
        logic [7:0] hold_dec;
        logic [7:0] hold_next;

        always_comb begin
            // Map the raw request pair onto an effective set or clear.
            s_eff = set[gi] & ~clr[gi];
            c_eff = clr[gi] & ~set[gi];
            if (set[gi] && clr[gi]) begin
                case (CONFLICT_MODE)
                    1: s_eff = 1'b1;
                    2: c_eff = 1'b1;
                    3: begin
                        // Toggle: a toggle from 1 is a clear and so still
                        // respects the hold time.
                        s_eff = ~q_reg;
                        c_eff = q_reg;
                    end
                    default: ;  // hold: behave like an idle cycle
                endcase
            end

            hold_dec  = (hold_reg == 8'd0) ? 8'd0 : hold_reg - 8'd1;
            q_next    = q_reg;
            pend_next = pend_reg;
            hold_next = hold_dec;

            if (s_eff) begin
                q_next    = 1'b1;
                pend_next = 1'b0;
                if (!q_reg) begin
                    hold_next = HOLD_LOAD;
                end
            end else if (q_reg && (c_eff || pend_reg)) begin
                // The clear lands on the edge where the hold counter reaches
                // zero, so q stays high for exactly MIN_HIGH cycles minimum.
                if (hold_dec == 8'd0) begin
                    q_next    = 1'b0;
                    pend_next = 1'b0;
                end else begin
                    pend_next = 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                q_reg    <= 1'b0;
                pend_reg <= 1'b0;
                hold_reg <= 8'd0;
                rise_reg <= 1'b0;
                fall_reg <= 1'b0;
            end else if (en) begin
                q_reg    <= q_next;
                pend_reg <= pend_next;
                hold_reg <= hold_next;
                rise_reg <= q_next & ~q_reg;
                fall_reg <= ~q_next & q_reg;
            end else begin
                rise_reg <= 1'b0;
                fall_reg <= 1'b0;
            end
        end

        assign q[gi]    = q_reg;
        assign pend[gi] = pend_reg;
        assign rise[gi] = rise_reg;
        assign fall[gi] = fall_reg;
    end

    assign qn = ~q;

    // -------------------------------------------------------------------------
    // Conflict statistics
    // -------------------------------------------------------------------------
    logic [PW-1:0] conflict_pop;
    logic [SW-1:0] sum_base;
    logic [SW-1:0] sum;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          sticky_reg;
    logic          sticky_next;

    always_comb begin
        conflict_pop = '0;
        if (en) begin
            for (int i = 0; i < CH; i++) begin
                conflict_pop = conflict_pop + PW'(set[i] & clr[i]);
            end
        end
    end

    always_comb begin
        // clr_stat restarts from zero but still counts this cycle's conflicts.
        sum_base    = clr_stat ? '0 : {{PW{1'b0}}, cnt_reg};
        sum         = sum_base + {{CW{1'b0}}, conflict_pop};
        cnt_next    = (sum > CNT_MAX) ? {CW{1'b1}} : sum[CW-1:0];
        sticky_next = (clr_stat ? 1'b0 : sticky_reg) | (conflict_pop != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg    <= '0;
            sticky_reg <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            sticky_reg <= sticky_next;
        end
    end

    assign conflict_cnt    = cnt_reg;
    assign conflict_sticky = sticky_reg;

endmodule

// File: tb/tb_nor_srff_bank.sv
// -----------------------------------------------------------------------------
// tb_nor_srff_bank
//
// Four CH=4, MIN_HIGH=0, CW=2 instances (one per CONFLICT_MODE, index 0..3) and
// one CH=4, CONFLICT_MODE=3, MIN_HIGH=3, CW=8 instance (index 4) share the same
// stimulus. Each directed step drives the inputs and queues hand-computed
// expectations tagged with the edge they apply to; a monitor process pops and
// compares them shortly after that edge.
// -----------------------------------------------------------------------------
module tb_nor_srff_bank;

    localparam int F_Q = 0, F_QN = 1, F_RISE = 2, F_FALL = 3, F_PEND = 4,
                   F_CNT = 5, F_STK = 6;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] set = '0;
    logic [3:0] clr = '0;
    logic       clr_stat = 1'b0;

    logic [3:0] m_q    [4];
    logic [3:0] m_qn   [4];
    logic [3:0] m_rise [4];
    logic [3:0] m_fall [4];
    logic [3:0] m_pend [4];
    logic [1:0] m_cnt  [4];
    logic       m_stk  [4];

    logic [3:0] h_q, h_qn, h_rise, h_fall, h_pend;
    logic [7:0] h_cnt;
    logic       h_stk;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_m
        nor_srff_bank #(.CH(4), .CONFLICT_MODE(gi), .MIN_HIGH(0), .CW(2)) u_dut (
            .clk(clk), .rst(rst), .en(en), .set(set), .clr(clr), .clr_stat(clr_stat),
            .q(m_q[gi]), .qn(m_qn[gi]), .rise(m_rise[gi]), .fall(m_fall[gi]),
            .pend(m_pend[gi]), .conflict_cnt(m_cnt[gi]), .conflict_sticky(m_stk[gi])
        );
    end

    nor_srff_bank #(.CH(4), .CONFLICT_MODE(3), .MIN_HIGH(3), .CW(8)) u_h (
        .clk(clk), .rst(rst), .en(en), .set(set), .clr(clr), .clr_stat(clr_stat),
        .q(h_q), .qn(h_qn), .rise(h_rise), .fall(h_fall),
        .pend(h_pend), .conflict_cnt(h_cnt), .conflict_sticky(h_stk)
    );

    typedef struct {
        int         tag;
        int         d;
        int         f;
        logic [7:0] v;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [7:0] get(int d, int f);
        logic [7:0] r;
        r = '0;
        if (d < 4) begin
            case (f)
                F_Q:    r = {4'b0, m_q[d]};
                F_QN:   r = {4'b0, m_qn[d]};
                F_RISE: r = {4'b0, m_rise[d]};
                F_FALL: r = {4'b0, m_fall[d]};
                F_PEND: r = {4'b0, m_pend[d]};
                F_CNT:  r = {6'b0, m_cnt[d]};
                default: r = {7'b0, m_stk[d]};
            endcase
        end else begin
            case (f)
                F_Q:    r = {4'b0, h_q};
                F_QN:   r = {4'b0, h_qn};
                F_RISE: r = {4'b0, h_rise};
                F_FALL: r = {4'b0, h_fall};
                F_PEND: r = {4'b0, h_pend};
                F_CNT:  r = h_cnt;
                default: r = {7'b0, h_stk};
            endcase
        end
        return r;
    endfunction

    // Monitor: after each rising edge, compare every expectation tagged for it.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (sb.size() > 0 && sb[0].tag <= cyc) begin
                exp_t e;
                logic [7:0] got;
                e = sb.pop_front();
                got = get(e.d, e.f);
                checks++;
                if (e.tag != cyc || got !== e.v) begin
                    errors++;
                    $display("FAIL %s dut%0d field%0d edge%0d got %0h expected %0h",
                             e.name, e.d, e.f, cyc, got, e.v);
                end else begin
                    $display("ok   %s dut%0d field%0d edge%0d value %0h",
                             e.name, e.d, e.f, cyc, got);
                end
            end
        end
    end

    task automatic step(input logic r, input logic e, input logic [3:0] s,
                        input logic [3:0] c, input logic cs);
        @(negedge clk);
        rst = r; en = e; set = s; clr = c; clr_stat = cs;
    endtask

    // Expectation for the next rising edge.
    task automatic ex(input string name, input int d, input int f, input logic [7:0] v);
        exp_t e;
        e.tag = cyc + 1; e.d = d; e.f = f; e.v = v; e.name = name;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        step(1, 0, 4'b0000, 4'b0000, 0);
        ex("rst_q", 0, F_Q, 8'h0);   ex("rst_qn", 0, F_QN, 8'hF);
        ex("rst_hq", H, F_Q, 8'h0);  ex("rst_hqn", H, F_QN, 8'hF);
        ex("rst_cnt", H, F_CNT, 8'h0); ex("rst_stk", H, F_STK, 8'h0);

        // Basic set / clr with and without hold
        step(0, 1, 4'b0001, 4'b0000, 0);
        ex("set_q", 0, F_Q, 8'h1);    ex("set_rise", 0, F_RISE, 8'h1);
        ex("set_fall", 0, F_FALL, 8'h0); ex("hset_q", H, F_Q, 8'h1);
        ex("hset_rise", H, F_RISE, 8'h1);
        step(0, 1, 4'b0000, 4'b0001, 0);
        ex("clr_q", 0, F_Q, 8'h0);    ex("clr_fall", 0, F_FALL, 8'h1);
        ex("clr_rise", 0, F_RISE, 8'h0); ex("hclr_q", H, F_Q, 8'h1);
        ex("hclr_pend", H, F_PEND, 8'h1); ex("hclr_fall", H, F_FALL, 8'h0);
        step(0, 1, 4'b0000, 4'b0000, 0);
        ex("fall_once", 0, F_FALL, 8'h0); ex("hold_pend", H, F_PEND, 8'h1);
        ex("hold_q", H, F_Q, 8'h1);
        step(0, 1, 4'b0000, 4'b0000, 0);
        ex("hexp_q", H, F_Q, 8'h0);   ex("hexp_pend", H, F_PEND, 8'h0);
        ex("hexp_fall", H, F_FALL, 8'h1);
        step(0, 1, 4'b0000, 4'b0000, 0);
        ex("hfall_once", H, F_FALL, 8'h0);

        // Conflict modes from q=0, then saturation on the CW=2 counters
        step(0, 1, 4'b0001, 4'b0001, 0);
        ex("m0_q", 0, F_Q, 8'h0); ex("m1_q", 1, F_Q, 8'h1);
        ex("m2_q", 2, F_Q, 8'h0); ex("m3_q", 3, F_Q, 8'h1);
        ex("m0_cnt", 0, F_CNT, 8'h1); ex("m1_cnt", 1, F_CNT, 8'h1);
        ex("m2_cnt", 2, F_CNT, 8'h1); ex("m3_cnt", 3, F_CNT, 8'h1);
        ex("m0_stk", 0, F_STK, 8'h1); ex("h_tgl_rise", H, F_RISE, 8'h1);
        step(0, 1, 4'b0001, 4'b0001, 0);
        ex("m3_tgl0", 3, F_Q, 8'h0); ex("cnt2", 0, F_CNT, 8'h2);
        ex("h_tgl_pend", H, F_PEND, 8'h1); ex("h_tgl_q", H, F_Q, 8'h1);
        ex("m1_hold1", 1, F_Q, 8'h1);
        step(0, 1, 4'b0001, 4'b0001, 0);
        ex("m3_tgl1", 3, F_Q, 8'h1); ex("cnt3", 1, F_CNT, 8'h3);
        ex("h_tgl_pend2", H, F_PEND, 8'h1);
        step(0, 1, 4'b0001, 4'b0001, 0);
        ex("m3_tgl2", 3, F_Q, 8'h0); ex("cnt_sat", 2, F_CNT, 8'h3);
        ex("h_tgl_clr", H, F_Q, 8'h0); ex("h_tgl_fall", H, F_FALL, 8'h1);
        ex("h_tgl_pend0", H, F_PEND, 8'h0);
        step(0, 1, 4'b0001, 4'b0001, 0);
        ex("m3_tgl3", 3, F_Q, 8'h1); ex("cnt_sat2", 0, F_CNT, 8'h3);
        ex("stk_sat", 0, F_STK, 8'h1); ex("h_cnt5", H, F_CNT, 8'h5);
        ex("h_rise2", H, F_RISE, 8'h1);

        // clr_stat alone, then clr_stat together with two conflicts
        step(0, 1, 4'b0000, 4'b0000, 1);
        ex("cs_cnt", 0, F_CNT, 8'h0); ex("cs_stk", 0, F_STK, 8'h0);
        ex("cs_hcnt", H, F_CNT, 8'h0); ex("cs_hstk", H, F_STK, 8'h0);
        step(0, 1, 4'b0011, 4'b0011, 1);
        ex("csc_cnt", 0, F_CNT, 8'h2); ex("csc_stk", 0, F_STK, 8'h1);
        ex("csc_hcnt", H, F_CNT, 8'h2); ex("m3_q2", 3, F_Q, 8'h2);
        ex("m1_q2", 1, F_Q, 8'h3);     ex("m2_q2", 2, F_Q, 8'h0);
        ex("h_q2", H, F_Q, 8'h3);      ex("h_pend2", H, F_PEND, 8'h1);
        ex("h_rise3", H, F_RISE, 8'h2);

        // en=0 freezes everything
        step(0, 0, 4'b1111, 4'b0000, 0);
        ex("en0_q", 0, F_Q, 8'h0); ex("en0_hq", H, F_Q, 8'h3);
        ex("en0_rise", H, F_RISE, 8'h0); ex("en0_hpend", H, F_PEND, 8'h1);
        step(0, 0, 4'b1111, 4'b0000, 0);
        ex("en0_q2", 1, F_Q, 8'h3); ex("en0_rise2", 0, F_RISE, 8'h0);
        step(0, 0, 4'b1111, 4'b1111, 0);
        ex("en0_cnt", 0, F_CNT, 8'h2); ex("en0_hcnt", H, F_CNT, 8'h2);
        ex("en0_q3", 0, F_Q, 8'h0);    ex("en0_hpend2", H, F_PEND, 8'h1);

        // Reset while a clear is pending
        step(1, 1, 4'b0000, 4'b0000, 0);
        ex("rp_q", H, F_Q, 8'h0); ex("rp_qn", H, F_QN, 8'hF);
        ex("rp_pend", H, F_PEND, 8'h0); ex("rp_fall", H, F_FALL, 8'h0);
        ex("rp_cnt", H, F_CNT, 8'h0); ex("rp_stk", H, F_STK, 8'h0);
        ex("rp_mq", 1, F_Q, 8'h0);

        // Normal operation right after reset; set cancels a pending clear
        step(0, 1, 4'b0100, 4'b0000, 0);
        ex("ar_q", 0, F_Q, 8'h4); ex("ar_hrise", H, F_RISE, 8'h4);
        ex("ar_hq", H, F_Q, 8'h4);
        step(0, 1, 4'b0000, 4'b0100, 0);
        ex("ar_fall", 0, F_FALL, 8'h4); ex("ar_hpend", H, F_PEND, 8'h4);
        step(0, 1, 4'b0100, 4'b0000, 0);
        ex("cancel_pend", H, F_PEND, 8'h0); ex("cancel_q", H, F_Q, 8'h4);
        ex("cancel_rise", H, F_RISE, 8'h0); ex("reset_rise", 0, F_RISE, 8'h4);
        step(0, 1, 4'b0000, 4'b0000, 0);
        ex("nopend_q", H, F_Q, 8'h4); ex("nopend_fall", H, F_FALL, 8'h0);
        step(0, 1, 4'b0000, 4'b0100, 0);
        ex("free_clr_q", H, F_Q, 8'h0); ex("free_clr_fall", H, F_FALL, 8'h4);
        ex("free_clr_qn", H, F_QN, 8'hF);

        step(0, 1, 4'b0000, 4'b0000, 0);
        repeat (3) @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain left %0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nor_srff_bank.md
NOR_SRFF_BANK -- requirements
Module: nor_srff_bank

Interface
REQ-001 Parameter CH, default 8, number of independent set/reset channels (1..32).
REQ-002 Parameter CONFLICT_MODE, default 0, set&clr simultaneous resolution: 0 hold, 1 set wins, 2 clr wins, 3 toggle.
REQ-003 Parameter MIN_HIGH, default 0, minimum cycles q stays 1 after rising before a clr may take effect (0..255).
REQ-004 Parameter CW, default 8, width of conflict counter.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 en  input  1  global update enable; 0 freezes q and hold counters.
REQ-008 set  input  CH  per-channel set request, sampled each clk.
REQ-009 clr  input  CH  per-channel clear request, sampled each clk.
REQ-010 clr_stat  input  1  clears conflict_cnt and conflict_sticky.
REQ-011 q  output  CH  registered latch state.
REQ-012 qn  output  CH  bitwise complement of q at all times, including reset.
REQ-013 rise  output  CH  one-cycle pulse, q went 0->1 on the last edge.
REQ-014 fall  output  CH  one-cycle pulse, q went 1->0 on the last edge.
REQ-015 pend  output  CH  clr accepted but deferred by MIN_HIGH hold.
REQ-016 conflict_cnt  output  CW  saturating count of channel-cycles with set&clr both 1 while en=1.
REQ-017 conflict_sticky  output  1  set once any conflict observed; cleared only by rst or clr_stat.

Function
REQ-018 Latency: set/clr sampled at edge k SHALL be reflected on q after edge k (one cycle).
REQ-019 en=0: q, pend, hold counters SHALL hold; rise/fall SHALL be 0; conflicts SHALL not count.
REQ-020 set=1, clr=0: q SHALL become 1; pend cleared; hold counter loaded with MIN_HIGH if q was 0.
REQ-021 set=0, clr=0: q SHALL hold; hold counter decrements toward 0 if nonzero.
REQ-022 clr=1, set=0, hold counter 0 (or MIN_HIGH=0): q SHALL become 0 that edge.
REQ-023 clr=1, set=0, hold counter nonzero: q SHALL stay 1, pend SHALL be set, counter decrements.
REQ-024 pend=1 and hold counter reaches 0: q SHALL clear on the edge where counter is 0, pend cleared, fall pulsed; a set arriving meanwhile cancels pend.
REQ-025 set&clr both 1: resolved per CONFLICT_MODE; mode 2 SHALL obey the MIN_HIGH hold like a plain clr; mode 3 toggle from 1 SHALL also obey hold (deferred via pend).
REQ-026 Per-channel states: LOW, HIGH_HOLD (counter>0), HIGH_FREE, HIGH_PEND; transitions only as REQ-020..025.
REQ-027 rise/fall derived from registered q vs previous q; never both 1 on one channel.
REQ-028 conflict_cnt SHALL add popcount(set&clr) per cycle, saturating at 2^CW-1, no wrap.
REQ-029 clr_stat and a conflict in the same cycle: counter SHALL load that cycle's popcount, sticky SHALL reflect it.
REQ-030 Channels SHALL be fully independent; no cross-channel coupling except conflict statistics.

Reset
REQ-031 rst=1 at an edge SHALL force q=0, qn=all-ones, rise=fall=pend=0, hold counters 0, conflict_cnt=0, conflict_sticky=0.
REQ-032 rst SHALL override en, set, clr, clr_stat; rst mid-hold SHALL drop pending clears without fall pulse.
REQ-033 First edge after rst deasserts SHALL process inputs normally.

Verification
REQ-034 CH=4, MIN_HIGH=0: set=0001 one cycle -> q=0001, rise=0001 next cycle; clr=0001 -> q=0000, fall=0001.
REQ-035 MIN_HIGH=3: set ch0 at cycle 0, clr ch0 at cycle 1 -> pend=1 cycles 2..3, q falls after cycle 3 edge, single fall pulse.
REQ-036 CONFLICT_MODE 0..3 each: set=clr=1 on q=0 -> q stays 0 / 1 / 0 / 1; conflict_cnt increments by 1 each.
REQ-037 CW=2: 5 conflict cycles on 1 channel -> conflict_cnt=3 saturated, sticky=1; clr_stat -> 0,0.
REQ-038 en=0 with set=1111 for 3 cycles -> q unchanged, no rise, no conflict counting.
REQ-039 rst asserted while pend=1 and q=1 -> next cycle q=0, pend=0, fall=0, stats zeroed.
